uart_receiver: RTL and testbench

Serial receive side of the APB UART peripheral: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from the asynchronous rx line and presents each byte to the APB register file with ready, framing-error and overrun flags. Bit period is runtime-programmable from the baud register, in system-clock cycles per bit, with the same encoding the transmit path uses. Samples each bit once at its centre.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_receiver.sv | 159 +++++++++++++++
 tb/tb_uart_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// bit-period clamp used by both serial directions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int          UART_DATA_BITS = 8;
    localparam logic [31:0] UART_MIN_DIV   = 32'd2;

    // A bit period below two cycles leaves no centre to sample.
    function automatic logic [31:0] clamp_div(input logic [31:0] baud);
        return (baud < UART_MIN_DIV) ? UART_MIN_DIV : baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronizer for the asynchronous rx line, idling high, with a falling-edge
// strobe on the synchronized value.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    output logic rx_s,
    output logic fall_s
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Shift the line through the chain and keep last cycle's output for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], serial_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rx_s   = sync_r[SYNC_STAGES-1];
    assign fall_s = prev_r & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 receive path: centre-samples each bit at a runtime-programmable bit
// period and hands bytes to the register file with ready/framing/overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [31:0]          baudData,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    logic                 rx_s;
    logic                 fall_s;
    rx_state_t            state_r;
    rx_state_t            state_s;
    logic [31:0]          div_r;
    logic [31:0]          cnt_r;
    logic [3:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 stop_r;
    logic                 stop_done_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 data_ready_r;
    logic                 framing_r;
    logic                 overrun_r;
    logic                 busy_r;
    logic                 half_end_s;
    logic                 bit_end_s;
    logic                 commit_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_s      (rx_s),
        .fall_s    (fall_s)
    );

    assign half_end_s = (cnt_r == ({1'b0, div_r[31:1]} - 32'd1));
    assign bit_end_s  = (cnt_r == (div_r - 32'd1));
    assign commit_s   = (state_r == STOP) && stop_done_r;

    // Next-state selection for the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_s = START;
                else        state_s = IDLE;
            end
            START: begin
                if (half_end_s) state_s = rx_s ? IDLE : DATA;
                else            state_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == 4'(DATA_BITS - 1))) state_s = STOP;
                else                                               state_s = DATA;
            end
            STOP: begin
                if (stop_done_r) state_s = IDLE;
                else             state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, bit-period counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            div_r       <= UART_MIN_DIV;
            cnt_r       <= 32'd0;
            bit_idx_r   <= 4'd0;
            shift_r     <= {DATA_BITS{1'b0}};
            stop_r      <= 1'b0;
            stop_done_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    cnt_r       <= 32'd0;
                    stop_done_r <= 1'b0;
                    if (fall_s) div_r <= clamp_div(baudData);
                end
                START: begin
                    if (half_end_s) begin
                        cnt_r     <= 32'd0;
                        bit_idx_r <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r     <= 32'd0;
                        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 4'd1;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                STOP: begin
                    // Hold after the stop sample so the commit lands on the next edge.
                    if (!stop_done_r) begin
                        if (bit_end_s) begin
                            stop_r      <= rx_s;
                            stop_done_r <= 1'b1;
                            cnt_r       <= 32'd0;
                        end else begin
                            cnt_r <= cnt_r + 32'd1;
                        end
                    end
                end
                default: cnt_r <= 32'd0;
            endcase
        end
    end

    // Register-file side: accept, overrun or clear on read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r    <= {DATA_BITS{1'b0}};
            data_ready_r <= 1'b0;
            framing_r    <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (commit_s) begin
            if (!data_ready_r || data_read) begin
                rx_data_r    <= shift_r;
                data_ready_r <= 1'b1;
                framing_r    <= ~stop_r;
                if (data_read) overrun_r <= 1'b0;
            end else begin
                overrun_r <= 1'b1;
            end
        end else if (data_read) begin
            data_ready_r <= 1'b0;
            framing_r    <= 1'b0;
            overrun_r    <= 1'b0;
        end
    end

    assign rx_data       = rx_data_r;
    assign data_ready    = data_ready_r;
    assign framing_error = framing_r;
    assign overrun_error = overrun_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a frame-level model predicts the register
// file outputs every cycle, with literal checks pinning key values.
module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic [31:0] baudData;
    logic        data_read;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        framing_error;
    logic        overrun_error;
    logic        busy;

    always #5 clk = ~clk;

    uart_receiver #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .baudData      (baudData),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        logic [7:0] b;
        logic       stop;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data;
    logic       m_ready, m_fe, m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: a frame's byte lands at a fixed cycle after its start bit.
    initial begin
        logic dr, r, com;
        ev_t  e;
        forever begin
            @(posedge clk);
            dr = data_read;
            r  = rst;
            cyc++;
            if (r) begin
                m_data = 8'h00; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
                evq.delete();
            end else begin
                com = 1'b0;
                if (evq.size() > 0 && evq[0].at == cyc) begin
                    e   = evq.pop_front();
                    com = 1'b1;
                end
                if (com) begin
                    if (!m_ready || dr) begin
                        m_data  = e.b;
                        m_ready = 1'b1;
                        m_fe    = !e.stop;
                        if (dr) m_ov = 1'b0;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else if (dr) begin
                    m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
                end
            end
            #1;
            check("outputs", {21'd0, rx_data, data_ready, framing_error, overrun_error},
                  {21'd0, m_data, m_ready, m_fe, m_ov});
        end
    end

    // Drives one 8N1 frame from a negedge; the byte commits 2 sync + 1 detect
    // + half + 9 bit periods + 1 commit cycles after the start-bit drive.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        int  div;
        ev_t e;
        div    = (baudData < 32'd2) ? 2 : int'(baudData);
        e.at   = cyc + 4 + (div >> 1) + 9 * div;
        e.b    = b;
        e.stop = stop;
        evq.push_back(e);
        serial_in = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (div) @(negedge clk);
        end
        serial_in = stop;
        repeat (div) @(negedge clk);
        serial_in = 1'b1;
        repeat (div + 8) @(negedge clk);
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int nb;
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0; baudData = 32'd16;
        repeat (3) @(negedge clk);
        check("reset_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5 at 16 cycles/bit, with end-to-end latency measured
        c0 = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                int n = 0;
                while (!data_ready && n < 400) begin
                    @(negedge clk);
                    n++;
                    if (n == 50) check("busy_mid_frame", {31'd0, busy}, 32'd1);
                end
                check("latency_a5", cyc - c0, 32'd156);
            end
        join
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);
        check("a5_busy_end", {31'd0, busy}, 32'd0);
        read_pulse();

        // 5-cycle glitch: busy for half a bit, no byte
        nb = 0;
        fork
            begin
                serial_in = 1'b0;
                repeat (5) @(negedge clk);
                serial_in = 1'b1;
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (busy) nb++;
                end
            end
        join
        check("glitch_busy_cycles", nb, 32'd8);
        check("glitch_no_ready", {31'd0, data_ready}, 32'd0);
        send_frame(8'h3C, 1'b1);
        check("3c_data", {24'd0, rx_data}, 32'h3C);
        read_pulse();

        // stop bit low
        send_frame(8'h81, 1'b0);
        check("81_data", {24'd0, rx_data}, 32'h81);
        check("81_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b110);
        read_pulse();
        check("81_cleared", {29'd0, data_ready, framing_error, overrun_error}, 32'd0);

        // overrun, then read coinciding with a commit
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun_data", {24'd0, rx_data}, 32'h11);
        check("overrun_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b101);
        c0 = cyc;
        fork
            send_frame(8'h33, 1'b1);
            begin
                while (cyc < c0 + 155) @(negedge clk);
                data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
            end
        join
        check("read_commit_data", {24'd0, rx_data}, 32'h33);
        check("read_commit_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);
        read_pulse();

        // divisors below the minimum behave as 2 cycles/bit
        baudData = 32'd0;
        send_frame(8'h5A, 1'b1);
        check("div0_data", {24'd0, rx_data}, 32'h5A);
        check("div0_ready", {31'd0, data_ready}, 32'd1);
        read_pulse();
        baudData = 32'd1;
        send_frame(8'h5A, 1'b1);
        check("div1_data", {24'd0, rx_data}, 32'h5A);
        check("div1_ready", {31'd0, data_ready}, 32'd1);

        // reset in the middle of 0xFF, with an unread byte pending
        baudData = 32'd16;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check("midrst_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'd0);
                check("midrst_busy", {31'd0, busy}, 32'd0);
                check("midrst_data", {24'd0, rx_data}, 32'd0);
                rst = 1'b0;
            end
        join
        send_frame(8'h0F, 1'b1);
        check("0f_data", {24'd0, rx_data}, 32'h0F);
        check("0f_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
